// File: rtl/apple1_loader_pkg.sv
// Shared constants and state encoding for the host-side RAM loader.
// Contents:
//   ADDR_W_DEF / LEN_W_DEF  default address and length widths
//   CMD_WRITE / CMD_READ    command bytes from the host ('W' / 'R')
//   ACK_BYTE                byte returned after a write transfer ('K')
//   state_e                 loader FSM states
package apple1_loader_pkg;

    localparam int unsigned ADDR_W_DEF = 15;
    localparam int unsigned LEN_W_DEF  = 16;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] ACK_BYTE  = 8'h4B;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_HDR2,
        ST_HDR3,
        ST_WRITE,
        ST_ACK,
        ST_RD_ISSUE,
        ST_RD_CAP,
        ST_RD_SEND
    } state_e;

endpackage

// File: rtl/ram_host_loader.sv
// Host-side master for the Apple-1 embedded RAM port.
// Receives 'W'/'R' commands with a big-endian 4-byte header (address, length)
// over a valid/ready byte link, then writes the following data bytes into RAM
// or streams RAM contents back to the host. busy holds the CPU off the RAM
// for the duration of a transfer.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   rx_data/valid/ready  command and data bytes from the host
//   tx_data/valid/ready  bytes to the host ('K' ack or read data)
//   ram_we/addr/din      RAM write/address port (one write per cycle max)
//   ram_dout             registered RAM read data, valid one cycle after addr
//   busy                 transfer in progress
//   err                  one-cycle pulse on an unknown command byte
module ram_host_loader
    import apple1_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout,
    output logic              busy,
    output logic              err
);

    state_e            state_q;
    logic              is_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  count_q;
    logic [7:0]        tx_data_q;
    logic              tx_valid_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [7:0]        ram_din_q;
    logic              busy_q;
    logic              err_q;

    logic              rx_fire_d;
    logic              tx_fire_d;
    logic [LEN_W-1:0]  len_d;
    logic [ADDR_W-1:0] addr_inc_d;

    // In WRITE the loader stops taking bytes once the last one is in; the
    // remaining WRITE cycle is the write of that last byte.
    always_comb begin
        rx_ready = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ST_IDLE, ST_HDR0, ST_HDR1, ST_HDR2, ST_HDR3: rx_ready = 1'b1;
                ST_WRITE: rx_ready = (count_q != '0);
                default:  rx_ready = 1'b0;
            endcase
        end
    end

    assign rx_fire_d  = rx_valid && rx_ready;
    assign tx_fire_d  = tx_valid_q && tx_ready;
    assign len_d      = {count_q[LEN_W-1:8], rx_data};
    assign addr_inc_d = addr_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            count_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ram_we_q <= 1'b0;
            err_q    <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_fire_d) begin
                        if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                            is_write_q <= (rx_data == CMD_WRITE);
                            busy_q     <= 1'b1;
                            state_q    <= ST_HDR0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_HDR0: if (rx_fire_d) begin
                    // High address bits beyond ADDR_W fall off in the cast.
                    addr_q  <= ADDR_W'({rx_data, 8'h00});
                    state_q <= ST_HDR1;
                end
                ST_HDR1: if (rx_fire_d) begin
                    addr_q  <= {addr_q[ADDR_W-1:8], rx_data};
                    state_q <= ST_HDR2;
                end
                ST_HDR2: if (rx_fire_d) begin
                    count_q <= LEN_W'({rx_data, 8'h00});
                    state_q <= ST_HDR3;
                end
                ST_HDR3: if (rx_fire_d) begin
                    count_q <= len_d;
                    if (is_write_q) begin
                        state_q <= (len_d != '0) ? ST_WRITE : ST_ACK;
                        if (len_d == '0) begin
                            tx_data_q  <= ACK_BYTE;
                            tx_valid_q <= 1'b1;
                        end
                    end else if (len_d != '0) begin
                        // Address goes out now so RAM data is ready in RD_CAP.
                        ram_addr_q <= addr_q;
                        state_q    <= ST_RD_ISSUE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (rx_fire_d) begin
                        ram_we_q   <= 1'b1;
                        ram_addr_q <= addr_q;
                        ram_din_q  <= rx_data;
                        addr_q     <= addr_inc_d;
                        count_q    <= count_q - LEN_W'(1);
                    end else if (count_q == '0) begin
                        tx_data_q  <= ACK_BYTE;
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_ACK;
                    end
                end
                ST_ACK: if (tx_fire_d) begin
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                ST_RD_ISSUE: begin
                    ram_addr_q <= addr_q;
                    state_q    <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    tx_data_q  <= ram_dout;
                    tx_valid_q <= 1'b1;
                    state_q    <= ST_RD_SEND;
                end
                ST_RD_SEND: if (tx_fire_d) begin
                    tx_valid_q <= 1'b0;
                    addr_q     <= addr_inc_d;
                    count_q    <= count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        ram_addr_q <= addr_inc_d;
                        state_q    <= ST_RD_ISSUE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ram_host_loader.sv
module tb_ram_host_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        ram_we;
    logic [14:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    // RAM model and activity counters
    logic [7:0]  mem [0:32767];
    int          wr_cnt = 0;
    int          tx_cnt = 0;
    int          err_cnt = 0;
    logic [14:0] wr_a [$];
    logic [7:0]  wr_d [$];

    always #5 clk = ~clk;

    ram_host_loader #(.ADDR_W(15), .LEN_W(16)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy), .err(err)
    );

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            wr_cnt <= wr_cnt + 1;
            wr_a.push_back(ram_addr);
            wr_d.push_back(ram_din);
        end
        ram_dout <= mem[ram_addr];
        if (tx_valid && tx_ready && !reset) tx_cnt <= tx_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            step(1);
            n++;
        end
        if (n >= 50) chk("rx_timeout", 32'(n), 32'(0));
        step(1);
        rx_valid = 1'b0;
    endtask

    // Wait for a TX byte, hold it stalled for 'stall' cycles checking it stays
    // put, then accept it and compare against the expected value.
    task automatic recv(input string tag, input logic [7:0] exp, input int stall);
        int n = 0;
        logic [7:0] held;
        while (!tx_valid && n < 50) begin
            step(1);
            n++;
        end
        if (n >= 50) chk({tag, "_timeout"}, 32'(n), 32'(0));
        held = tx_data;
        for (int i = 0; i < stall; i++) begin
            step(1);
            if (tx_data !== held || tx_valid !== 1'b1) chk({tag, "_stall"}, {23'd0, tx_valid, tx_data}, {24'd1, held});
        end
        chk(tag, {24'd0, tx_data}, {24'd0, exp});
        tx_ready = 1'b1;
        step(1);
        tx_ready = 1'b0;
    endtask

    initial begin
        int w0;
        int t0;
        int e0;
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        step(2);

        // Reset state (still in reset)
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_outs", {15'd0, tx_valid, tx_data}, 32'd0);
        chk("rst_ram", {7'd0, ram_we, ram_addr, ram_din}, 32'd0);
        chk("rst_busy_err", {30'd0, busy, err}, 32'd0);
        reset = 1'b0;
        step(1);
        chk("idle_rx_ready", {31'd0, rx_ready}, 32'd1);

        // Write 3 bytes at 0x0010
        send(8'h57);
        chk("busy_after_cmd", {31'd0, busy}, 32'd1);
        send(8'h00); send(8'h10); send(8'h00); send(8'h03);
        send(8'hAA); send(8'hBB); send(8'hCC);
        recv("wr_ack", 8'h4B, 2);
        chk("wr_busy_clear", {31'd0, busy}, 32'd0);
        chk("wr_count", 32'(wr_cnt), 32'd3);
        chk("wr0", {9'd0, wr_a[0], wr_d[0]}, {9'd0, 15'h0010, 8'hAA});
        chk("wr1", {9'd0, wr_a[1], wr_d[1]}, {9'd0, 15'h0011, 8'hBB});
        chk("wr2", {9'd0, wr_a[2], wr_d[2]}, {9'd0, 15'h0012, 8'hCC});

        // Read back with 5-cycle stalls
        t0 = tx_cnt;
        send(8'h52); send(8'h00); send(8'h10); send(8'h00); send(8'h03);
        chk("rd_rx_ready_low", {31'd0, rx_ready}, 32'd0);
        recv("rd0", 8'hAA, 5);
        recv("rd1", 8'hBB, 5);
        recv("rd2", 8'hCC, 5);
        step(10);
        chk("rd_tx_count", 32'(tx_cnt - t0), 32'd3);
        chk("rd_idle", {30'd0, busy, tx_valid}, 32'd0);
        chk("rd_no_writes", 32'(wr_cnt), 32'd3);

        // Address wrap at the top of RAM
        w0 = wr_cnt;
        send(8'h57); send(8'h7F); send(8'hFF); send(8'h00); send(8'h02);
        send(8'h11); send(8'h22);
        recv("wrap_ack", 8'h4B, 0);
        chk("wrap_count", 32'(wr_cnt - w0), 32'd2);
        chk("wrap_wr0", {9'd0, wr_a[w0], wr_d[w0]}, {9'd0, 15'h7FFF, 8'h11});
        chk("wrap_wr1", {9'd0, wr_a[w0+1], wr_d[w0+1]}, {9'd0, 15'h0000, 8'h22});
        send(8'h52); send(8'hFF); send(8'hFF); send(8'h00); send(8'h02);
        recv("wrap_rd0", 8'h11, 0);
        recv("wrap_rd1", 8'h22, 1);
        step(3);
        chk("wrap_rd_busy", {31'd0, busy}, 32'd0);

        // Zero-length write and read
        w0 = wr_cnt;
        send(8'h57); send(8'h12); send(8'h34); send(8'h00); send(8'h00);
        recv("zero_wr_ack", 8'h4B, 0);
        chk("zero_wr_none", 32'(wr_cnt - w0), 32'd0);
        t0 = tx_cnt;
        send(8'h52); send(8'h12); send(8'h34); send(8'h00);
        chk("zero_rd_busy_hdr", {31'd0, busy}, 32'd1);
        send(8'h00);
        chk("zero_rd_busy", {31'd0, busy}, 32'd0);
        step(8);
        chk("zero_rd_no_tx", {31'(tx_cnt - t0), tx_valid}, 32'd0);

        // Unknown command
        e0 = err_cnt;
        send(8'h41);
        chk("err_pulse", {30'd0, err, busy}, 32'b10);
        step(1);
        chk("err_clear", {31'd0, err}, 32'd0);
        step(3);
        chk("err_count", 32'(err_cnt - e0), 32'd1);
        chk("err_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a 4-byte write
        w0 = wr_cnt;
        t0 = tx_cnt;
        send(8'h57); send(8'h01); send(8'h00); send(8'h00); send(8'h04);
        send(8'h11); send(8'h22);
        reset = 1'b1;
        step(1);
        chk("mid_rst_outs", {14'd0, busy, tx_valid, tx_data}, 32'd0);
        chk("mid_rst_ram", {7'd0, ram_we, ram_addr, ram_din}, 32'd0);
        chk("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        step(1);
        reset = 1'b0;
        step(10);
        chk("mid_rst_writes", 32'(wr_cnt - w0), 32'd2);
        chk("mid_rst_no_tx", {31'(tx_cnt - t0), tx_valid}, 32'd0);
        send(8'h52); send(8'h01); send(8'h00); send(8'h00); send(8'h02);
        recv("mid_rd0", 8'h11, 0);
        recv("mid_rd1", 8'h22, 0);
        step(3);
        chk("mid_rd_busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_host_loader.md
Name: ram_host_loader

Overview:
- Host-side master for the 32 KB Apple-1 embedded RAM port (clk/we/address/din/dout; synchronous write; registered read data valid one cycle after address).
- Takes a byte-stream command protocol from the host link (UART RX/TX FIFOs, valid/ready), then writes byte blocks into RAM or streams blocks back out.
- Holds the 6502 off the RAM via `busy` while a transfer is in progress.
- Used to preload programs and dump memory without going through WozMon.

Parameters:
- ADDR_W, 15, RAM address width; addresses wrap modulo 2^ADDR_W.
- LEN_W, 16, width of the transfer length field.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  command/data byte from host.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts rx_data this cycle.
- tx_data  out  8  byte to host.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  host side accepts tx_data.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  8  RAM write data.
- ram_dout  in  8  RAM read data (registered in RAM, valid the cycle after ram_addr is presented with ram_we=0).
- busy  out  1  transfer in progress; arbiter gives the RAM port to the loader.
- err  out  1  one-cycle pulse when an unknown command byte is received.

Behaviour:
- Reset (sampled at posedge): state=IDLE, rx_ready=0 during the reset cycle, tx_valid=0, tx_data=0, ram_we=0, ram_addr=0, ram_din=0, busy=0, err=0.
- Reset mid-transfer aborts at once. No further RAM writes or TX bytes. Bytes already written stay in RAM.
- Handshakes:
  - A byte transfers on posedge when valid&&ready.
  - tx_data and tx_valid stay stable while tx_valid&&!tx_ready.
  - rx_ready is 1 only in IDLE, HDR states and WRITE.
- Protocol:
  - Command byte: 'W'=0x57 or 'R'=0x52.
  - Header: ADDR_H, ADDR_L, LEN_H, LEN_L (big-endian). Address bits above ADDR_W are ignored.
  - LEN is the number of data bytes; 0 is legal.
- States: IDLE, HDR0..HDR3, WRITE, ACK, RD_ISSUE, RD_CAP, RD_SEND.
- IDLE:
  - Accept byte. W/R: store cmd, busy<=1, go to HDR0.
  - Any other byte: err pulses 1 cycle, stay IDLE, busy stays 0.
- HDR0..HDR3: accept one byte each. After HDR3:
  - W with len>0 -> WRITE.
  - W with len=0 -> ACK.
  - R with len>0 -> RD_ISSUE.
  - R with len=0 -> IDLE, busy<=0.
- WRITE:
  - On each accepted byte, the next cycle drives ram_we=1, ram_addr=cur_addr, ram_din=byte, for exactly one cycle.
  - Then cur_addr<=cur_addr+1 (wraps 0x7FFF->0x0000) and count decrements.
  - Back-to-back accepts give one write per cycle.
  - After the last byte's write cycle -> ACK.
- ACK: tx_data=0x4B ('K'), tx_valid=1 until accepted; then IDLE, busy<=0.
- RD_ISSUE: ram_we=0, ram_addr=cur_addr; -> RD_CAP.
- RD_CAP: tx_data<=ram_dout, tx_valid<=1; -> RD_SEND.
- RD_SEND:
  - On tx accept: tx_valid<=0, cur_addr+1 (wrapping), count-1.
  - If count reaches 0 -> IDLE with busy<=0; else -> RD_ISSUE.
- Read throughput: at most 1 byte per 3 cycles.
- ram_we is 0 in every state except the single write cycles.
- No new command is accepted while busy=1.
- ram_addr holds its last value when idle.

Decomposition:
- Package apple1_loader_pkg holds:
  - CMD_WRITE=8'h57, CMD_READ=8'h52, ACK_BYTE=8'h4B.
  - The state enum.
  - Default ADDR_W/LEN_W constants.
- No sub-module. The single FSM plus address/count registers is the natural unit; the RAM instance stays outside the block.

Test Plan:
- Write: reset, then 57 00 10 00 03 AA BB CC -> ram writes at 0x0010=AA, 0x0011=BB, 0x0012=CC, one ram_we cycle each. Then tx 0x4B, busy back to 0.
- Read-back: 52 00 10 00 03 with tx_ready held low 5 cycles per byte -> tx sends AA, BB, CC in order, tx_data stable while stalled, exactly 3 bytes.
- Wrap: 57 7F FF 00 02 11 22 -> writes 0x7FFF=11, 0x0000=22. Read 52 FF FF 00 02 -> 11, 22 (top address bit ignored).
- Zero length and error:
  - 57 12 34 00 00 -> no ram_we, tx 0x4B.
  - 52 12 34 00 00 -> no tx, IDLE.
  - 0x41 -> err pulses once, busy stays 0.
- Reset mid-write: 57 01 00 00 04 11 22, then reset -> no further ram_we, all outputs at reset values. Next command 52 01 00 00 02 -> 11, 22.
